sat_mac_accum: RTL and testbench

- Streaming signed multiply-accumulate stage with saturating arithmetic. It consumes operand pairs and emits one saturated dot-product result per vector.
- Sits directly downstream of the operand source and feeds the datapath's saturating-add consumers.
- Every intermediate value is clamped to WIDTH bits, using the same overflow/saturation semantics as the team's saturating adder.
- Includes a 2-stage pipeline, a valid/ready handshake on both sides and a small control FSM.

---
 rtl/sat_mac_accum.sv | 179 +++++++++++++++++
 tb/tb_sat_mac_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sat_mac_accum.sv
// sat_mac_accum: streaming signed multiply-accumulate with saturating
// arithmetic. Each vector of operand pairs (terminated by in_last) yields one
// clamped dot product, a sticky saturation flag and a saturating term count.
//
// Pipeline:
//   accept edge E0 : clamped product registered (stage 1)
//   edge E1        : product folded into the accumulator (stage 2)
//   edge E2        : accumulator copied to the output registers, out_valid=1
// The result therefore appears two cycles after the last beat is accepted,
// whatever the vector length.
module sat_mac_accum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sum,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        out_count
);

    // Saturation limits derived from WIDTH, plus the same limits widened to
    // the full product width for the stage-1 range compare.
    localparam logic signed [WIDTH-1:0]   MAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   MIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] MAX_P  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MIN_P  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Stage valid/last shift registers: bit 0 = stage-1 product present,
    // bit 1 = stage 2 consumed a product on the previous edge.
    logic [1:0]              r_vld_pipe;
    logic [1:0]              r_last_pipe;

    logic signed [WIDTH-1:0] r_s1_prod;
    logic                    r_s1_sat;

    logic signed [WIDTH-1:0] r_acc;
    logic                    r_sticky;
    logic [CNT_W-1:0]        r_cnt;

    logic signed [WIDTH-1:0] r_out_sum;
    logic                    r_out_sat;
    logic [CNT_W-1:0]        r_out_count;

    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_drain_done;
    logic signed [2*WIDTH-1:0] w_prod_full;
    logic                    w_prod_hi;
    logic                    w_prod_lo;
    logic signed [WIDTH-1:0] w_prod_clamp;
    logic signed [WIDTH:0]   w_sum;
    logic                    w_acc_ovf;
    logic signed [WIDTH-1:0] w_acc_clamp;

    assign in_ready     = (r_state == ST_ACCUM);
    assign out_valid    = (r_state == ST_DONE);
    assign out_sum      = r_out_sum;
    assign out_sat      = r_out_sat;
    assign out_count    = r_out_count;

    assign w_accept     = in_valid & in_ready;
    assign w_out_hs     = out_valid & out_ready;
    // Last product of the vector has been absorbed into r_acc.
    assign w_drain_done = r_vld_pipe[1] & r_last_pipe[1];

    // Stage 1 combinational: full-width signed product clamped to WIDTH bits.
    always_comb begin
        w_prod_full  = in_a * in_b;
        w_prod_hi    = (w_prod_full > MAX_P);
        w_prod_lo    = (w_prod_full < MIN_P);
        w_prod_clamp = w_prod_full[WIDTH-1:0];
        if (w_prod_hi)
            w_prod_clamp = MAX;
        else if (w_prod_lo)
            w_prod_clamp = MIN;
    end

    // Stage 2 combinational: WIDTH+1-bit sum; a disagreement between the two
    // top bits means same-sign operands produced an opposite-sign result.
    always_comb begin
        w_sum       = {r_acc[WIDTH-1], r_acc} + {r_s1_prod[WIDTH-1], r_s1_prod};
        w_acc_ovf   = w_sum[WIDTH] ^ w_sum[WIDTH-1];
        w_acc_clamp = w_sum[WIDTH-1:0];
        if (w_acc_ovf)
            w_acc_clamp = w_sum[WIDTH] ? MIN : MAX;
    end

    // Valid/last shift registers for the two pipeline stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[0], w_accept};
            r_last_pipe <= {r_last_pipe[0] & r_vld_pipe[0], w_accept & in_last};
        end
    end

    // Stage-1 product register, loaded only on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_prod <= '0;
            r_s1_sat  <= 1'b0;
        end else if (w_accept) begin
            r_s1_prod <= w_prod_clamp;
            r_s1_sat  <= w_prod_hi | w_prod_lo;
        end
    end

    // Stage-2 accumulator, sticky flag and saturating count; cleared when the
    // result is taken. No product can be in flight during DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_out_hs) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (r_vld_pipe[0]) begin
            r_acc    <= w_acc_clamp;
            r_sticky <= r_sticky | r_s1_sat | w_acc_ovf;
            if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output registers: captured once when the vector finishes draining and
    // held through DONE until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sum   <= '0;
            r_out_sat   <= 1'b0;
            r_out_count <= '0;
        end else if ((r_state == ST_DRAIN) && w_drain_done) begin
            r_out_sum   <= r_acc;
            r_out_sat   <= r_sticky;
            r_out_count <= r_cnt;
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_ACCUM;
        else
            r_state <= w_state_nxt;
    end

    // Control FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_accept && in_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done)        w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)           w_state_nxt = ST_ACCUM;
            default:                           w_state_nxt = ST_ACCUM;
        endcase
    end

endmodule

// File: tb/tb_sat_mac_accum.sv
// Self-checking bench for sat_mac_accum: hand-computed vector table, directed
// corner sequences, and random vectors scored against an integer model.
module tb_sat_mac_accum;

    localparam int W    = 16;
    localparam int CW   = 8;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));
    localparam int CMAX = (1 << CW) - 1;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_a;
    logic signed [W-1:0] in_b;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_sum;
    logic                out_sat;
    logic [CW-1:0]       out_count;

    sat_mac_accum #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];

    typedef struct {
        int n;
        int a[4];
        int b[4];
        int exp_sum;
        bit exp_sat;
        int exp_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, exp);
        end
    endtask

    // Reference: clamp each product, then clamp each running sum.
    function automatic void model(output int s, output bit sat, output int cnt);
        longint acc, p;
        acc = 0; sat = 0;
        foreach (qa[i]) begin
            p = longint'(qa[i]) * longint'(qb[i]);
            if (p > MAXV) begin p = MAXV; sat = 1; end
            if (p < MINV) begin p = MINV; sat = 1; end
            acc = acc + p;
            if (acc > MAXV) begin acc = MAXV; sat = 1; end
            if (acc < MINV) begin acc = MINV; sat = 1; end
        end
        s   = int'(acc);
        cnt = (qa.size() > CMAX) ? CMAX : qa.size();
    endfunction

    // Drive the queued vector, optionally with idle gaps, then confirm the
    // result appears exactly two edges after the last beat is accepted.
    task automatic send_vec(input int gap_max);
        int n;
        int gap;
        n = qa.size();
        for (int i = 0; i < n; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_a = 16'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'(qa[i]);
            in_b     = 16'(qb[i]);
            in_last  = (i == n - 1);
            check("in_ready_accum", in_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_ready_drain", in_ready, 0);
        check("valid_lat0", out_valid, 0);
        @(negedge clk);
        check("valid_lat1", out_valid, 0);
        @(negedge clk);
        check("valid_lat2", out_valid, 1);
    endtask

    // Check the result, stall the consumer for 'hold' cycles while offering
    // junk beats that must be ignored, then complete the handshake.
    task automatic finish_vec(input int es, input bit esat, input int ecnt, input int hold);
        check("out_sum", int'(out_sum), es);
        check("out_sat", out_sat, esat);
        check("out_count", out_count, ecnt);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_sum", int'(out_sum), es);
            check("hold_cnt", out_count, ecnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    int  ms;
    bit  msat;
    int  mcnt;
    int  len;

    initial begin
        tbl[0] = '{3, '{3, -2, 7, 0},           '{4, 5, -1, 0},  -5,     1'b0, 3};
        tbl[1] = '{1, '{-32768, 0, 0, 0},       '{-32768, 0, 0, 0}, 32767, 1'b1, 1};
        tbl[2] = '{2, '{16384, 1, 0, 0},        '{2, 1, 0, 0},   32767,  1'b1, 2};
        tbl[3] = '{2, '{-20000, -20000, 0, 0},  '{1, 1, 0, 0},   -32768, 1'b1, 2};
        tbl[4] = '{1, '{5, 0, 0, 0},            '{1, 0, 0, 0},   5,      1'b0, 1};
        tbl[5] = '{3, '{32767, 1, -1, 0},       '{1, 1, 1, 0},   32766,  1'b1, 3};
        tbl[6] = '{1, '{0, 0, 0, 0},            '{0, 0, 0, 0},   0,      1'b0, 1};
        tbl[7] = '{3, '{-32768, -1, 1, 0},      '{1, 1, 1, 0},   -32767, 1'b1, 3};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_sum", int'(out_sum), 0);
        check("rst_sat", out_sat, 0);
        check("rst_cnt", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors; the first gets a 10-cycle consumer stall.
        for (int t = 0; t < 8; t++) begin
            qa.delete(); qb.delete();
            for (int j = 0; j < tbl[t].n; j++) begin
                qa.push_back(tbl[t].a[j]);
                qb.push_back(tbl[t].b[j]);
            end
            send_vec(0);
            finish_vec(tbl[t].exp_sum, tbl[t].exp_sat, tbl[t].exp_cnt, (t == 0) ? 10 : 0);
        end

        // Asynchronous reset mid-vector after 5 beats; outputs still hold the
        // previous nonzero result right up to the reset.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 16'sd1; in_b = 16'sd1; in_last = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", int'(out_sum), 0);
        check("mid_rst_sat", out_sat, 0);
        check("mid_rst_cnt", out_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        qa = '{2}; qb = '{3};
        send_vec(0);
        finish_vec(6, 1'b0, 1, 0);

        // Long vector: count saturates, sum does not.
        qa.delete(); qb.delete();
        for (int i = 0; i < 300; i++) begin qa.push_back(1); qb.push_back(1); end
        send_vec(0);
        finish_vec(300, 1'b0, 255, 0);

        // Random vectors with bubbles and consumer stalls.
        for (int r = 0; r < 40; r++) begin
            qa.delete(); qb.delete();
            len = int'($urandom_range(6, 1));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(1, 0) == 1) begin
                    qa.push_back(int'($signed(16'($urandom))));
                    qb.push_back(int'($signed(16'($urandom))));
                end else begin
                    qa.push_back(int'($urandom_range(400, 0)) - 200);
                    qb.push_back(int'($urandom_range(400, 0)) - 200);
                end
            end
            model(ms, msat, mcnt);
            send_vec(2);
            finish_vec(ms, msat, mcnt, int'($urandom_range(3, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
